mem_loader: RTL and testbench

- Serial-driven memory initiator: receives command frames from rs232in and issues word reads/writes on the mem_* bus, the same bus the CPU drives and sram_ctrl answers.
- Replies go back through rs232out.
- Used for image download and memory inspection without the CPU.
- Sits beside yari. An external arbiter grants it the mem_* bus while `active`=1.

---
 rtl/mem_loader.sv | 174 +++++++++++++++++
 tb/tb_mem_loader.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_loader.sv
// mem_loader: serial command interpreter that drives word reads/writes on the
// shared mem_* bus and answers through the serial transmitter.
module mem_loader #(
  parameter logic [1:0] MEM_ID  = 2'd3,
  parameter int         TIMEOUT = 1024
) (
  input  logic        clock,
  input  logic        rst,
  input  logic [7:0]  rs232in_data,
  input  logic        rs232in_attention,
  input  logic        rs232out_busy,
  output logic        rs232out_w,
  output logic [7:0]  rs232out_d,
  input  logic        mem_waitrequest,
  output logic [1:0]  mem_id,
  output logic [29:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  output logic [3:0]  mem_writedatamask,
  input  logic [31:0] mem_readdata,
  input  logic [1:0]  mem_readdataid,
  output logic        active
);

  localparam int            TW         = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [7:0]    CMD_W      = 8'h57;
  localparam logic [7:0]    CMD_R      = 8'h52;
  localparam logic [7:0]    REPLY_OK   = 8'h2E;
  localparam logic [7:0]    REPLY_TO   = 8'h21;
  localparam logic [7:0]    REPLY_UNK  = 8'h3F;

  typedef enum logic [2:0] {IDLE, ADDR, DATA, WREQ, RREQ, RWAIT, TX} state_t;

  state_t        state;
  state_t        state_next;
  logic [7:0]    cmd;
  logic [1:0]    count;
  logic [23:0]   addr_hi;
  logic [TW-1:0] timer;
  logic [31:0]   tx_buf;
  logic [2:0]    tx_cnt;

  logic is_cmd;
  logic rd_match;
  logic timed_out;
  logic tx_go;
  logic last_byte;

  assign mem_id            = MEM_ID;
  assign mem_writedatamask = 4'hF;

  assign is_cmd    = (rs232in_data == CMD_W) || (rs232in_data == CMD_R);
  assign rd_match  = (mem_readdataid == MEM_ID);
  assign timed_out = (timer == TIMER_LAST);
  // A strobe is never issued right after another so the busy rise is observed.
  assign tx_go     = !rs232out_busy && !rs232out_w;
  assign last_byte = (count == 2'd3);

  // State register.
  always_ff @(posedge clock) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state decode plus the bus request strobes and the active flag.
  always_comb begin
    state_next = state;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    active     = 1'b1;
    case (state)
      IDLE: begin
        active = 1'b0;
        if (rs232in_attention) state_next = is_cmd ? ADDR : TX;
      end
      ADDR: begin
        if (rs232in_attention && last_byte) state_next = (cmd == CMD_W) ? DATA : RREQ;
      end
      DATA: begin
        if (rs232in_attention && last_byte) state_next = WREQ;
      end
      WREQ: begin
        mem_write = 1'b1;
        if (!mem_waitrequest) state_next = TX;
      end
      RREQ: begin
        mem_read = 1'b1;
        if (!mem_waitrequest) state_next = RWAIT;
      end
      RWAIT: begin
        if (rd_match || timed_out) state_next = TX;
      end
      TX: begin
        if (tx_go && (tx_cnt == 3'd1)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: frame assembly, read capture, timeout timer and reply shifter.
  always_ff @(posedge clock) begin
    if (!rst) begin
      cmd           <= 8'h00;
      count         <= 2'd0;
      addr_hi       <= 24'h0;
      mem_address   <= 30'h0;
      mem_writedata <= 32'h0;
      timer         <= '0;
      tx_buf        <= 32'h0;
      tx_cnt        <= 3'd0;
      rs232out_w    <= 1'b0;
      rs232out_d    <= 8'h00;
    end else begin
      rs232out_w <= 1'b0;
      case (state)
        IDLE: begin
          if (rs232in_attention) begin
            cmd   <= rs232in_data;
            count <= 2'd0;
            if (!is_cmd) begin
              tx_buf <= {REPLY_UNK, 24'h0};
              tx_cnt <= 3'd1;
            end
          end
        end
        ADDR: begin
          if (rs232in_attention) begin
            count <= count + 2'd1;
            if (last_byte) mem_address <= {addr_hi, rs232in_data[7:2]};
            else           addr_hi     <= {addr_hi[15:0], rs232in_data};
          end
        end
        DATA: begin
          if (rs232in_attention) begin
            count         <= count + 2'd1;
            mem_writedata <= {mem_writedata[23:0], rs232in_data};
          end
        end
        WREQ: begin
          if (!mem_waitrequest) begin
            tx_buf <= {REPLY_OK, 24'h0};
            tx_cnt <= 3'd1;
          end
        end
        RREQ: begin
          if (!mem_waitrequest) timer <= '0;
        end
        RWAIT: begin
          if (rd_match) begin
            tx_buf <= mem_readdata;
            tx_cnt <= 3'd4;
          end else if (timed_out) begin
            tx_buf <= {REPLY_TO, 24'h0};
            tx_cnt <= 3'd1;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        TX: begin
          if (tx_go) begin
            rs232out_w <= 1'b1;
            rs232out_d <= tx_buf[31:24];
            tx_buf     <= {tx_buf[23:0], 8'h00};
            tx_cnt     <= tx_cnt - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: directed frames with a queue-based scoreboard for memory
// accesses and transmitted reply bytes.
module tb_mem_loader;

  logic        clock = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rs232in_data = 8'h00;
  logic        rs232in_attention = 1'b0;
  logic        rs232out_busy = 1'b0;
  logic        rs232out_w;
  logic [7:0]  rs232out_d;
  logic        mem_waitrequest = 1'b0;
  logic [1:0]  mem_id;
  logic [29:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic [3:0]  mem_writedatamask;
  logic [31:0] mem_readdata = 32'h0;
  logic [1:0]  mem_readdataid = 2'd0;
  logic        active;

  mem_loader #(.MEM_ID(2'd3), .TIMEOUT(16)) dut (
    .clock(clock), .rst(rst),
    .rs232in_data(rs232in_data), .rs232in_attention(rs232in_attention),
    .rs232out_busy(rs232out_busy), .rs232out_w(rs232out_w), .rs232out_d(rs232out_d),
    .mem_waitrequest(mem_waitrequest), .mem_id(mem_id), .mem_address(mem_address),
    .mem_read(mem_read), .mem_write(mem_write), .mem_writedata(mem_writedata),
    .mem_writedatamask(mem_writedatamask), .mem_readdata(mem_readdata),
    .mem_readdataid(mem_readdataid), .active(active)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        wr;
    logic [29:0] addr;
    logic [31:0] data;
    int          hold;
  } mem_exp_t;

  typedef struct {
    logic [7:0] b;
    logic       last;
  } tx_exp_t;

  mem_exp_t mem_q[$];
  tx_exp_t  tx_q[$];
  int checks = 0;
  int passed = 0;

  // Responder / transmitter configuration written by the stimulus process.
  int          stall_cfg = 0;
  int          ev1_delay = 0;
  logic [1:0]  ev1_id = 2'd0;
  logic [31:0] ev1_data = 32'h0;
  int          ev2_delay = 0;
  logic [1:0]  ev2_id = 2'd0;
  logic [31:0] ev2_data = 32'h0;
  logic        force_busy = 1'b0;

  logic prev_w = 1'b0;
  logic prev_busy = 1'b0;
  int   req_run = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    rs232in_data      = b;
    rs232in_attention = 1'b1;
    tick(1);
    rs232in_attention = 1'b0;
    tick(1);
  endtask

  task automatic sendWord(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) applyStimulus(w[i*8 +: 8]);
  endtask

  task automatic expectMem(input logic wr, input logic [29:0] addr, input logic [31:0] data, input int hold);
    mem_exp_t e;
    e.wr = wr; e.addr = addr; e.data = data; e.hold = hold;
    mem_q.push_back(e);
  endtask

  task automatic expectTx(input logic [7:0] b, input logic last);
    tx_exp_t t;
    t.b = b; t.last = last;
    tx_q.push_back(t);
  endtask

  task automatic waitDone(input string name);
    int n = 0;
    while ((tx_q.size() != 0 || mem_q.size() != 0 || active) && n < 300) begin
      tick(1);
      n++;
    end
    checkOutput({name, "_pending"}, tx_q.size() + mem_q.size(), 0);
    checkOutput({name, "_idle"}, {31'b0, active}, 0);
  endtask

  // Memory responder: programmable stall, then tagged read data after acceptance.
  always @(posedge clock) begin
    static bit in_req = 0;
    static int stall_left = 0;
    static bit rd_acc_prev = 0;
    static bit armed = 0;
    static int cnt = 0;
    #1;
    mem_readdataid = 2'd0;
    mem_readdata   = 32'h0;
    if (rd_acc_prev) begin
      armed = 1;
      cnt   = 0;
    end
    if (armed) begin
      cnt++;
      if (cnt == ev1_delay) begin
        mem_readdataid = ev1_id;
        mem_readdata   = ev1_data;
      end else if (cnt == ev2_delay) begin
        mem_readdataid = ev2_id;
        mem_readdata   = ev2_data;
      end
      if (cnt >= 40) armed = 0;
    end
    if (mem_read || mem_write) begin
      if (!in_req) begin
        in_req     = 1;
        stall_left = stall_cfg;
      end
      if (stall_left > 0) begin
        mem_waitrequest = 1'b1;
        stall_left--;
      end else begin
        mem_waitrequest = 1'b0;
      end
    end else begin
      in_req          = 0;
      mem_waitrequest = 1'b0;
    end
    rd_acc_prev = mem_read && !mem_waitrequest;
  end

  // Transmitter model: busy for three cycles after each strobe, or while forced.
  always @(posedge clock) begin
    static int busy_cnt = 0;
    #1;
    if (prev_w) busy_cnt = 3;
    else if (busy_cnt > 0) busy_cnt--;
    rs232out_busy = force_busy || (busy_cnt > 0);
  end

  // Monitor: pops the scoreboard on every bus acceptance and every strobe.
  always @(negedge clock) begin
    mem_exp_t e;
    tx_exp_t  t;
    if (rst) begin
      if (mem_read || mem_write) begin
        req_run++;
        if (!mem_waitrequest) begin
          if (mem_q.size() == 0) begin
            checkOutput("mem_unexpected", {30'b0, mem_write, mem_read}, 0);
          end else begin
            e = mem_q.pop_front();
            checkOutput("mem_kind", {30'b0, mem_write, mem_read}, e.wr ? 32'd2 : 32'd1);
            checkOutput("mem_addr", {2'b0, mem_address}, {2'b0, e.addr});
            checkOutput("mem_hold", req_run, e.hold);
            checkOutput("mem_tag", {26'b0, mem_id, mem_writedatamask}, {26'b0, 2'd3, 4'hF});
            if (e.wr) checkOutput("mem_data", mem_writedata, e.data);
          end
          req_run = 0;
        end
      end else begin
        req_run = 0;
      end
      if (rs232out_w) begin
        if (tx_q.size() == 0) begin
          checkOutput("tx_unexpected", {24'h1, rs232out_d}, 0);
        end else begin
          t = tx_q.pop_front();
          checkOutput("tx_byte", {24'h0, rs232out_d}, {24'h0, t.b});
          checkOutput("tx_spacing", {30'b0, prev_busy, prev_w}, 0);
          checkOutput("tx_active", {31'b0, active}, {31'b0, ~t.last});
        end
      end
    end
    prev_w    = rs232out_w;
    prev_busy = rs232out_busy;
  end

  // Directed scenario sequence.
  initial begin
    int n;
    tick(3);
    checkOutput("rst_active", {31'b0, active}, 0);
    checkOutput("rst_req", {30'b0, mem_read, mem_write}, 0);
    checkOutput("rst_tx", {23'b0, rs232out_w, rs232out_d}, 0);
    checkOutput("rst_addr", {2'b0, mem_address}, 0);
    checkOutput("rst_wdata", mem_writedata, 0);
    checkOutput("rst_const", {26'b0, mem_id, mem_writedatamask}, {26'b0, 2'd3, 4'hF});
    rst = 1'b1;
    tick(2);

    $display("[TB] write frame");
    stall_cfg = 0;
    expectMem(1'b1, 30'h1000_0004, 32'hDEAD_BEEF, 1);
    expectTx(8'h2E, 1'b1);
    applyStimulus(8'h57);
    sendWord(32'h4000_0010);
    sendWord(32'hDEAD_BEEF);
    waitDone("write");

    $display("[TB] read with stall");
    stall_cfg = 5;
    ev1_delay = 7; ev1_id = 2'd3; ev1_data = 32'h1234_5678;
    ev2_delay = 0;
    expectMem(1'b0, 30'h1000_0004, 32'h0, 6);
    expectTx(8'h12, 1'b0); expectTx(8'h34, 1'b0);
    expectTx(8'h56, 1'b0); expectTx(8'h78, 1'b1);
    applyStimulus(8'h52);
    sendWord(32'h4000_0010);
    waitDone("read_stall");

    $display("[TB] read timeout");
    stall_cfg = 0;
    ev1_delay = 5;  ev1_id = 2'd1; ev1_data = 32'h0000_0BAD;
    ev2_delay = 20; ev2_id = 2'd3; ev2_data = 32'h0000_BAD2;
    expectMem(1'b0, 30'h40, 32'h0, 1);
    expectTx(8'h21, 1'b1);
    applyStimulus(8'h52);
    sendWord(32'h0000_0100);
    waitDone("timeout");
    tick(30);
    ev2_delay = 0;
    checkOutput("timeout_late", tx_q.size() + mem_q.size(), 0);

    $display("[TB] unknown byte and drops");
    force_busy = 1'b1;
    tick(2);
    expectTx(8'h3F, 1'b1);
    applyStimulus(8'h41);
    applyStimulus(8'h57);
    applyStimulus(8'h52);
    tick(3);
    checkOutput("unk_active", {31'b0, active}, 1);
    force_busy = 1'b0;
    waitDone("unknown");
    expectMem(1'b1, 30'h2, 32'h0102_0304, 1);
    expectTx(8'h2E, 1'b1);
    applyStimulus(8'h57);
    sendWord(32'h0000_0008);
    sendWord(32'h0102_0304);
    waitDone("after_unknown");

    $display("[TB] reset mid-write");
    stall_cfg = 1000;
    applyStimulus(8'h57);
    sendWord(32'h0000_0100);
    sendWord(32'hAABB_CCDD);
    n = 0;
    while (!mem_write && n < 20) begin
      tick(1);
      n++;
    end
    checkOutput("rst_wreq_seen", {31'b0, mem_write}, 1);
    tick(3);
    rst = 1'b0;
    tick(1);
    checkOutput("midrst_req", {30'b0, mem_read, mem_write}, 0);
    checkOutput("midrst_active", {31'b0, active}, 0);
    checkOutput("midrst_addr", {2'b0, mem_address}, 0);
    checkOutput("midrst_wdata", mem_writedata, 0);
    rst = 1'b1;
    stall_cfg = 0;
    tick(2);
    ev1_delay = 3; ev1_id = 2'd3; ev1_data = 32'hA5A5_5A5A;
    expectMem(1'b0, 30'h10, 32'h0, 1);
    expectTx(8'hA5, 1'b0); expectTx(8'hA5, 1'b0);
    expectTx(8'h5A, 1'b0); expectTx(8'h5A, 1'b1);
    applyStimulus(8'h52);
    sendWord(32'h0000_0040);
    waitDone("after_reset");

    $display("[TB] busy backpressure");
    force_busy = 1'b1;
    tick(2);
    ev1_delay = 2; ev1_id = 2'd3; ev1_data = 32'hCAFE_F00D;
    expectMem(1'b0, 30'h8, 32'h0, 1);
    expectTx(8'hCA, 1'b0); expectTx(8'hFE, 1'b0);
    expectTx(8'hF0, 1'b0); expectTx(8'h0D, 1'b1);
    applyStimulus(8'h52);
    sendWord(32'h0000_0020);
    tick(30);
    checkOutput("bp_held", tx_q.size(), 4);
    force_busy = 1'b0;
    waitDone("backpressure");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
